// File: rtl/data_sync_mc.sv
// data_sync_mc: multi-channel request/data synchroniser into the clk domain.
//
// Each channel's asynchronous request runs through a STAGES-deep flop chain.
// A detected request event (rising edge in MODE 0, any change in MODE 1)
// captures that channel's data word and raises a valid flag. The consumer
// clears the flag with a take. An event that lands on a still-valid,
// untaken word sets a sticky overrun flag. The synced request level is
// returned to the source as an acknowledge. After reset a short settle
// window suppresses events so that sources already active at release do
// not produce false captures.
//
// Ports:
//   clk          destination clock
//   rst          async active-high reset
//   din          CHANNELS*DWIDTH source data, channel c at [c*DWIDTH +: DWIDTH]
//   dready_i     per-channel asynchronous request
//   dtake_i      per-channel consumer take
//   ovr_clr_i    per-channel overrun clear
//   dout         captured data, same slicing as din
//   dvalid_o     per-channel unconsumed-word flag
//   dack_o       per-channel registered synced request level
//   overrun_o    per-channel sticky overwrite flag
//   init_done_o  settle window complete

// One channel: sync chain, event detect, capture register, flags.
module data_sync_mc_lane #(
    parameter int STAGES = 2,
    parameter int DWIDTH = 8,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              req_i,
    input  logic [DWIDTH-1:0] din_i,
    input  logic              take_i,
    input  logic              ovr_clr_i,
    output logic [DWIDTH-1:0] dout_o,
    output logic              dvalid_o,
    output logic              dack_o,
    output logic              overrun_o
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              dack_q, dack_d;
    logic              overrun_q, overrun_d;
    logic              synced;
    logic              ev;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], req_i};
        synced = sync_q[STAGES-1];
        // prev follows synced even while events are masked, so a level
        // that settled during the settle window is not seen as an edge.
        prev_d = synced;
        if (MODE == 1) begin
            ev = en_i & (synced ^ prev_q);
        end else begin
            ev = en_i & synced & ~prev_q;
        end
        dout_d    = ev ? din_i : dout_q;
        // An event and a take on the same edge leave a fresh valid word.
        dvalid_d  = ev | (dvalid_q & ~take_i);
        // Set beats clear when both happen together.
        overrun_d = (ev & dvalid_q & ~take_i) | (overrun_q & ~ovr_clr_i);
        dack_d    = en_i & synced;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            dack_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            dack_q    <= dack_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout_o    = dout_q;
    assign dvalid_o  = dvalid_q;
    assign dack_o    = dack_q;
    assign overrun_o = overrun_q;
endmodule

module data_sync_mc #(
    parameter int STAGES   = 2,
    parameter int DWIDTH   = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*DWIDTH-1:0]   din,
    input  logic [CHANNELS-1:0]          dready_i,
    input  logic [CHANNELS-1:0]          dtake_i,
    input  logic [CHANNELS-1:0]          ovr_clr_i,
    output logic [CHANNELS*DWIDTH-1:0]   dout,
    output logic [CHANNELS-1:0]          dvalid_o,
    output logic [CHANNELS-1:0]          dack_o,
    output logic [CHANNELS-1:0]          overrun_o,
    output logic                         init_done_o
);
    if (STAGES < 2) begin : g_bad_stages
        $error("data_sync_mc: STAGES must be >= 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("data_sync_mc: CHANNELS must be >= 1");
    end

    localparam int CW = $clog2(STAGES + 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          init_done_q, init_done_d;

    // Counts release edges; done is registered on the (STAGES+1)th edge,
    // after which the counter freezes.
    always_comb begin
        cnt_d       = init_done_q ? cnt_q : cnt_q + CW'(1);
        init_done_d = init_done_q | (cnt_q == CW'(STAGES));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done_o = init_done_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        data_sync_mc_lane #(
            .STAGES (STAGES),
            .DWIDTH (DWIDTH),
            .MODE   (MODE)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en_i      (init_done_q),
            .req_i     (dready_i[c]),
            .din_i     (din[c*DWIDTH +: DWIDTH]),
            .take_i    (dtake_i[c]),
            .ovr_clr_i (ovr_clr_i[c]),
            .dout_o    (dout[c*DWIDTH +: DWIDTH]),
            .dvalid_o  (dvalid_o[c]),
            .dack_o    (dack_o[c]),
            .overrun_o (overrun_o[c])
        );
    end
endmodule
